// File: rtl/sargantana_icache_pkg.sv
// Shared types and default geometry for the icache lookup/refill controller.
package sargantana_icache_pkg;

  localparam int IC_N_WAY  = 4;
  localparam int IC_IDX_W  = 6;
  localparam int IC_TAG_W  = 20;
  localparam int IC_LINE_W = 128;
  localparam int IC_BEAT_W = 64;

  localparam int N_BEATS        = IC_LINE_W / IC_BEAT_W;
  localparam int BEAT_CNT_WIDTH = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    MISS_REQ,
    MISS_WAIT,
    WRITE
  } refill_state_t;

  // Latched lookup; doubles as the L2 line address {tag,idx}.
  typedef struct packed {
    logic [IC_TAG_W-1:0] tag;
    logic [IC_IDX_W-1:0] idx;
  } l2_req_t;

endpackage

// File: rtl/sargantana_icache_refill_buffer.sv
// Beat counter plus line assembly register for L2 refills.
module sargantana_icache_refill_buffer #(
  parameter int LINE_W = 128,
  parameter int BEAT_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              beat_valid_i,
  input  logic [BEAT_W-1:0] beat_data_i,
  output logic [LINE_W-1:0] line_o,
  output logic              last_beat_o
);

  localparam int NB = LINE_W / BEAT_W;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0]     cnt_q;
  logic [LINE_W-1:0] line_q;

  assign last_beat_o = beat_valid_i & (cnt_q == CW'(NB - 1));
  assign line_o      = line_q;

  // Place each beat at its slot and advance; wrap on the last beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (beat_valid_i) begin
      line_q[cnt_q*BEAT_W +: BEAT_W] <= beat_data_i;
      cnt_q <= last_beat_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/sargantana_icache_refill_ctrl.sv
// Icache lookup/miss controller: compare, L2 line fetch, refill write, forward.
module sargantana_icache_refill_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int ICACHE_N_WAY      = IC_N_WAY,
  parameter int ICACHE_IDX_WIDTH  = IC_IDX_W,
  parameter int ICACHE_TAG_WIDTH  = IC_TAG_W,
  parameter int ICACHE_LINE_WIDTH = IC_LINE_W,
  parameter int L2_BEAT_WIDTH     = IC_BEAT_W
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     req_valid_i,
  output logic                                     req_ready_o,
  input  logic [ICACHE_IDX_WIDTH-1:0]              req_idx_i,
  input  logic [ICACHE_TAG_WIDTH-1:0]              req_tag_i,
  input  logic                                     kill_i,
  input  logic                                     flush_i,
  input  logic                                     hit_i,
  output logic                                     cache_rd_ena_o,
  output logic                                     cache_wr_ena_o,
  output logic [ICACHE_IDX_WIDTH-1:0]              cline_index_o,
  output logic                                     cmp_en_o,
  input  logic [$clog2(ICACHE_N_WAY)-1:0]          way_to_replace_d_i,
  output logic [$clog2(ICACHE_N_WAY)-1:0]          way_to_replace_q_o,
  output logic                                     l2_req_valid_o,
  input  logic                                     l2_req_ready_i,
  output logic [ICACHE_TAG_WIDTH+ICACHE_IDX_WIDTH-1:0] l2_req_addr_o,
  input  logic                                     l2_resp_valid_i,
  input  logic [L2_BEAT_WIDTH-1:0]                 l2_resp_data_i,
  output logic [ICACHE_LINE_WIDTH-1:0]             line_data_o,
  output logic [ICACHE_TAG_WIDTH-1:0]              line_tag_o,
  output logic                                     resp_valid_o,
  output logic                                     resp_miss_o
);

  localparam int WAY_W = $clog2(ICACHE_N_WAY);

  refill_state_t state_q, state_d;
  l2_req_t       req_q, req_d;
  logic [WAY_W-1:0] way_q;
  logic killed_q, killed_d, flushed_q, flushed_d;

  logic buf_clr, beat_vld, last_beat;
  logic [ICACHE_LINE_WIDTH-1:0] buf_line;
  logic abort;

  logic ready_c, rd_c, wr_c, cmp_c, l2v_c, rv_c, rm_c;
  logic [ICACHE_IDX_WIDTH-1:0] idx_c;

  assign abort    = kill_i | flush_i;
  assign beat_vld = (state_q == MISS_WAIT) & l2_resp_valid_i;
  assign buf_clr  = (state_q == MISS_REQ) & l2_req_ready_i;

  sargantana_icache_refill_buffer #(
    .LINE_W (ICACHE_LINE_WIDTH),
    .BEAT_W (L2_BEAT_WIDTH)
  ) u_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (buf_clr),
    .beat_valid_i (beat_vld),
    .beat_data_i  (l2_resp_data_i),
    .line_o       (buf_line),
    .last_beat_o  (last_beat)
  );

  // State, latched request, abort flags; replacement way loads only in COMPARE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      req_q     <= '0;
      way_q     <= '0;
      killed_q  <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      killed_q  <= killed_d;
      flushed_q <= flushed_d;
      if (state_q == COMPARE) way_q <= way_to_replace_d_i;
    end
  end

  // Next state and raw outputs.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    killed_d  = killed_q;
    flushed_d = flushed_q;
    ready_c   = 1'b0;
    rd_c      = 1'b0;
    wr_c      = 1'b0;
    cmp_c     = 1'b0;
    l2v_c     = 1'b0;
    rv_c      = 1'b0;
    rm_c      = 1'b0;
    idx_c     = req_q.idx;
    case (state_q)
      IDLE: begin
        ready_c = ~flush_i;
        if (req_valid_i && !flush_i) begin
          rd_c      = 1'b1;
          idx_c     = req_idx_i;
          req_d.idx = req_idx_i;
          req_d.tag = req_tag_i;
          state_d   = COMPARE;
        end
      end
      COMPARE: begin
        cmp_c = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (hit_i) begin
          rv_c    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        l2v_c = 1'b1;
        // Once the handshake completes the beats must be drained, so a
        // coincident abort only gets recorded.
        if (l2_req_ready_i) begin
          killed_d  = kill_i;
          flushed_d = flush_i;
          state_d   = MISS_WAIT;
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      MISS_WAIT: begin
        killed_d  = killed_q | kill_i;
        flushed_d = flushed_q | flush_i;
        if (last_beat) state_d = WRITE;
      end
      WRITE: begin
        wr_c      = ~flushed_q;
        rv_c      = ~killed_q & ~flushed_q & ~abort;
        rm_c      = rv_c;
        killed_d  = 1'b0;
        flushed_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs are forced low while reset is held.
  assign req_ready_o        = ready_c & ~rst_i;
  assign cache_rd_ena_o     = rd_c & ~rst_i;
  assign cache_wr_ena_o     = wr_c & ~rst_i;
  assign cmp_en_o           = cmp_c & ~rst_i;
  assign l2_req_valid_o     = l2v_c & ~rst_i;
  assign resp_valid_o       = rv_c & ~rst_i;
  assign resp_miss_o        = rm_c & ~rst_i;
  assign cline_index_o      = rst_i ? '0 : idx_c;
  assign way_to_replace_q_o = rst_i ? '0 : way_q;
  assign l2_req_addr_o      = rst_i ? '0 : req_q;
  assign line_data_o        = rst_i ? '0 : buf_line;
  assign line_tag_o         = rst_i ? '0 : req_q.tag;

endmodule

// File: tb/tb_sargantana_icache_refill_ctrl.sv
// Randomized transaction-level bench for the icache refill controller.
module tb_sargantana_icache_refill_ctrl;

  localparam int IW = 6, TW = 20, LW = 128, BW = 64, NB = LW / BW, WW = 2;
  localparam int M_HIT = 0, M_MISS = 1, M_KCMP = 2, M_FCMP = 3, M_KSTALL = 4,
                 M_KWAIT = 5, M_FWAIT = 6, M_AWR = 7, M_RST = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, req_valid, req_ready, kill, flush, hit;
  logic [IW-1:0] req_idx, cline_index;
  logic [TW-1:0] req_tag, line_tag;
  logic rd_ena, wr_ena, cmp_en, l2v, l2_rdy, l2_rv, resp_v, resp_m;
  logic [WW-1:0] way_d, way_q;
  logic [TW+IW-1:0] l2_addr;
  logic [BW-1:0] l2_rd;
  logic [LW-1:0] line_data;

  sargantana_icache_refill_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_idx_i(req_idx), .req_tag_i(req_tag),
    .kill_i(kill), .flush_i(flush), .hit_i(hit),
    .cache_rd_ena_o(rd_ena), .cache_wr_ena_o(wr_ena),
    .cline_index_o(cline_index), .cmp_en_o(cmp_en),
    .way_to_replace_d_i(way_d), .way_to_replace_q_o(way_q),
    .l2_req_valid_o(l2v), .l2_req_ready_i(l2_rdy), .l2_req_addr_o(l2_addr),
    .l2_resp_valid_i(l2_rv), .l2_resp_data_i(l2_rd),
    .line_data_o(line_data), .line_tag_o(line_tag),
    .resp_valid_o(resp_v), .resp_miss_o(resp_m)
  );

  int n_chk = 0, n_err = 0;
  bit in_wait = 1'b0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus must never present an L2 beat outside the refill window.
  always @(posedge clk)
    if (!rst) assert (!(l2_rv && !in_wait)) else $error("l2 beat outside refill window");

  task automatic next();
    @(negedge clk);
  endtask

  task automatic quiet();
    req_valid = 0; kill = 0; flush = 0; hit = 0; l2_rdy = 0; l2_rv = 0; l2_rd = '0;
  endtask

  function automatic logic [LW-1:0] all_ctl();
    return LW'({req_ready, rd_ena, wr_ena, cline_index, cmp_en, way_q, l2v, l2_addr, resp_v, resp_m});
  endfunction

  // One lookup, walked cycle by cycle; expectations follow from the scenario.
  task automatic run_txn(input int mode, input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                         input logic [WW-1:0] way, input int stall_in, input logic [LW-1:0] line);
    int stall;
    logic [LW-1:0] exp_line;
    bit wr_exp, rv_exp;
    stall = (mode == M_KSTALL && stall_in < 1) ? 1 : stall_in;
    if ($urandom_range(0, 3) == 0) begin
      flush = 1; req_valid = 1; req_idx = ~idx; req_tag = ~tag;
      #1 chk("flush_ready", req_ready, 0);
      chk("flush_rd", rd_ena, 0);
      next(); quiet();
    end
    // accept
    req_valid = 1; req_idx = idx; req_tag = tag;
    #1 chk("acc_ready", req_ready, 1);
    chk("acc_rd", rd_ena, 1);
    chk("acc_idx", cline_index, idx);
    chk("acc_cmp", cmp_en, 0);
    next(); quiet(); req_idx = '0; req_tag = '0;
    // compare
    way_d = way;
    hit  = (mode == M_HIT) || ((mode == M_KCMP || mode == M_FCMP) && $urandom_range(0, 1) == 1);
    kill = (mode == M_KCMP);
    flush = (mode == M_FCMP);
    #1 chk("cmp_en", cmp_en, 1);
    chk("cmp_ready", req_ready, 0);
    chk("cmp_rd", rd_ena, 0);
    chk("cmp_resp", resp_v, mode == M_HIT);
    chk("cmp_miss", resp_m, 0);
    chk("cmp_l2v", l2v, 0);
    next(); quiet(); way_d = ~way;
    if (mode == M_HIT || mode == M_KCMP || mode == M_FCMP) begin
      #1 chk("post_cmp_ready", req_ready, 1);
      chk("post_cmp_l2v", l2v, 0);
      chk("post_cmp_way", way_q, way);
      next();
      return;
    end
    // line request with stall
    for (int s = 0; s < stall; s++) begin
      kill = (mode == M_KSTALL && s == stall - 1);
      #1 chk("stall_l2v", l2v, 1);
      chk("stall_addr", l2_addr, {tag, idx});
      next(); quiet();
    end
    if (mode == M_KSTALL) begin
      #1 chk("kstall_l2v", l2v, 0);
      chk("kstall_ready", req_ready, 1);
      next();
      return;
    end
    l2_rdy = 1;
    #1 chk("hs_l2v", l2v, 1);
    chk("hs_addr", l2_addr, {tag, idx});
    next(); quiet();
    // beats
    in_wait = 1;
    exp_line = '0;
    for (int b = 0; b < NB; b++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        #1 chk("gap_wr", wr_ena, 0);
        chk("gap_resp", resp_v, 0);
        next();
      end
      l2_rv = 1; l2_rd = line[b*BW +: BW];
      exp_line[b*BW +: BW] = line[b*BW +: BW];
      kill  = (mode == M_KWAIT && b == NB - 1);
      flush = (mode == M_FWAIT && b == NB - 1);
      #1 chk("beat_wr", wr_ena, 0);
      chk("beat_l2v", l2v, 0);
      next(); quiet();
      if (mode == M_RST && b == 0 && NB > 1) begin
        rst = 1; in_wait = 0;
        #1 chk("rst_ctl", all_ctl(), 0);
        chk("rst_line", line_data, 0);
        chk("rst_tag", line_tag, 0);
        next(); rst = 0;
        #1 chk("rst_ready", req_ready, 1);
        chk("rst_way", way_q, 0);
        chk("rst_buf", line_data, 0);
        next();
        return;
      end
    end
    in_wait = 0;
    // write
    if (mode == M_AWR) begin
      if ($urandom_range(0, 1) == 1) kill = 1; else flush = 1;
    end
    wr_exp = (mode != M_FWAIT);
    rv_exp = (mode == M_MISS);
    #1 chk("wr_ena", wr_ena, wr_exp);
    chk("wr_rd", rd_ena, 0);
    chk("wr_resp", resp_v, rv_exp);
    chk("wr_miss", resp_m, rv_exp);
    chk("wr_line", line_data, exp_line);
    chk("wr_tag", line_tag, tag);
    chk("wr_idx", cline_index, idx);
    chk("wr_way", way_q, way);
    chk("wr_ready", req_ready, 0);
    next(); quiet();
    #1 chk("post_wr_ready", req_ready, 1);
    chk("post_wr_resp", resp_v, 0);
    next();
  endtask

  initial begin
    quiet(); way_d = '0; req_idx = '0; req_tag = '0;
    rst = 1;
    next(); next();
    #1 chk("reset_ctl", all_ctl(), 0);
    chk("reset_line", line_data, 0);
    next(); rst = 0;
    #1 chk("reset_ready", req_ready, 1);
    chk("reset_way", way_q, 0);
    next();

    run_txn(M_HIT,    6'h05, 20'hABCDE, 2'd0, 0, '0);
    run_txn(M_MISS,   6'h05, 20'hABCDE, 2'd2, 2,
            {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    run_txn(M_KWAIT,  6'h11, 20'h12345, 2'd1, 0, {$urandom, $urandom, $urandom, $urandom});
    run_txn(M_FWAIT,  6'h3F, 20'hFFFFF, 2'd3, 1, {$urandom, $urandom, $urandom, $urandom});
    run_txn(M_KSTALL, 6'h20, 20'h00001, 2'd1, 5, '0);
    run_txn(M_RST,    6'h0A, 20'h5A5A5, 2'd3, 0, {$urandom, $urandom, $urandom, $urandom});

    for (int i = 0; i < 80; i++) begin
      run_txn($urandom_range(0, 8), IW'($urandom), TW'($urandom), WW'($urandom),
              $urandom_range(0, 5), {$urandom, $urandom, $urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
